sobel_3x3_gray8: RTL and testbench

SOBEL_3X3_GRAY8 -- requirements
Module: sobel_3x3_gray8

---
 rtl/cam_pkg.sv | 16 +
 rtl/line_buffer_gray8.sv | 22 ++
 rtl/sobel_3x3_gray8.sv | 127 ++++++++++++
 tb/tb_sobel_3x3_gray8.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: shared camera-pipeline constants, pixel/gradient types and gradient helpers
package cam_pkg;
  localparam int IMG_WIDTH = 320;
  localparam int IMG_HEIGHT = 240;
  localparam int HPOS_W = $clog2(IMG_WIDTH);
  localparam int VPOS_W = $clog2(IMG_HEIGHT);
  localparam int GRAD_W = 11;
  typedef logic [7:0] gray8_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  function automatic grad_t sum121(input gray8_t a, input gray8_t b, input gray8_t c);
    return grad_t'({3'b000, a}) + grad_t'({2'b00, b, 1'b0}) + grad_t'({3'b000, c});
  endfunction
  function automatic logic [GRAD_W-1:0] grad_abs(input grad_t g);
    return g[GRAD_W-1] ? -g : g;
  endfunction
endpackage

// File: rtl/line_buffer_gray8.sv
// line_buffer_gray8: single-port line RAM, read-first with one-cycle registered read
module line_buffer_gray8
  import cam_pkg::*;
#(
  parameter int DEPTH = IMG_WIDTH,
  parameter int AW = HPOS_W
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  gray8_t        din,
  output gray8_t        dout
);
  gray8_t mem [DEPTH];
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      dout <= mem[addr];
    end
  end
endmodule

// File: rtl/sobel_3x3_gray8.sv
// sobel_3x3_gray8: 3x3 Sobel |Gx|+|Gy| on gray8 video, 3-cycle latency
// SOBEL_THRESH_EN: when defined, output is a binary edge map against the selected threshold
module sobel_3x3_gray8 #(
  parameter int IMG_WIDTH = cam_pkg::IMG_WIDTH,
  parameter logic [7:0] THRESH_DEFAULT = 8'd64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] pixel_in,
  input  logic       vsync,
  input  logic       active_area,
  input  logic       thresh_sel,
  input  logic [7:0] thresh_in,
  output logic [7:0] pixel_out,
  output logic       filter_ready
);
  import cam_pkg::*;
  logic vsync_q, act_q, first_line, vs_rise, act_rise, accept, wsel;
  logic [HPOS_W-1:0] hpos, h_cur, h_nxt;
  logic [VPOS_W-1:0] vpos, v_cur;
  gray8_t lb0_q, lb1_q, pix_d, top, mid, clamp, res;
  logic t0, t1, sel_d, brd0, brd1;
  gray8_t w [3][2];
  gray8_t p [3][3];
  grad_t gx, gy, gx1, gy1;
  logic [GRAD_W-1:0] mag;
  always_comb begin
    vs_rise = vsync & ~vsync_q;
    act_rise = active_area & ~act_q;
    accept = enable & active_area;
    h_cur = (vs_rise | act_rise) ? '0 : hpos;
    v_cur = vs_rise ? '0 : (act_rise & ~first_line) ? vpos + 1'b1 : vpos;
    h_nxt = (accept && h_cur != HPOS_W'(IMG_WIDTH - 1)) ? h_cur + 1'b1 : h_cur;
    wsel = v_cur[0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= 1'b0;
      act_q <= 1'b0;
      first_line <= 1'b1;
      hpos <= '0;
      vpos <= '0;
    end else begin
      vsync_q <= vsync;
      act_q <= active_area;
      first_line <= act_rise ? 1'b0 : vs_rise ? 1'b1 : first_line;
      hpos <= h_nxt;
      vpos <= v_cur;
    end
  end
  // Ping-pong rows: row v goes into buffer v[0], whose read-first output is row v-2
  line_buffer_gray8 #(.DEPTH(IMG_WIDTH)) u_lb0 (
    .clk(clk), .en(accept), .we(~wsel), .addr(h_cur), .din(pixel_in), .dout(lb0_q)
  );
  line_buffer_gray8 #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk(clk), .en(accept), .we(wsel), .addr(h_cur), .din(pixel_in), .dout(lb1_q)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      t0 <= 1'b0;
      pix_d <= '0;
      sel_d <= 1'b0;
      brd0 <= 1'b0;
    end else begin
      t0 <= accept;
      if (accept) begin
        pix_d <= pixel_in;
        sel_d <= wsel;
        brd0 <= ~|h_cur[HPOS_W-1:1] | ~|v_cur[VPOS_W-1:1];
      end
    end
  end
  always_comb begin
    top = sel_d ? lb1_q : lb0_q;
    mid = sel_d ? lb0_q : lb1_q;
    for (int r = 0; r < 3; r++) begin
      p[r][0] = w[r][0];
      p[r][1] = w[r][1];
    end
    p[0][2] = top;
    p[1][2] = mid;
    p[2][2] = pix_d;
    gx = sum121(p[0][2], p[1][2], p[2][2]) - sum121(p[0][0], p[1][0], p[2][0]);
    gy = sum121(p[2][0], p[2][1], p[2][2]) - sum121(p[0][0], p[0][1], p[0][2]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      t1 <= 1'b0;
      gx1 <= '0;
      gy1 <= '0;
      brd1 <= 1'b0;
      w <= '{default: '0};
    end else begin
      t1 <= t0;
      if (t0) begin
        gx1 <= gx;
        gy1 <= gy;
        brd1 <= brd0;
        for (int r = 0; r < 3; r++) begin
          w[r][0] <= w[r][1];
          w[r][1] <= p[r][2];
        end
      end
    end
  end
  always_comb begin
    mag = grad_abs(gx1) + grad_abs(gy1);
    clamp = |mag[GRAD_W-1:8] ? 8'hFF : mag[7:0];
  end
`ifdef SOBEL_THRESH_EN
  assign res = (clamp >= (thresh_sel ? thresh_in : THRESH_DEFAULT)) ? 8'hFF : 8'h00;
`else
  logic unused_thr;
  assign unused_thr = ^{thresh_sel, thresh_in, THRESH_DEFAULT};
  assign res = clamp;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_out <= 8'h00;
      filter_ready <= 1'b0;
    end else begin
      filter_ready <= t1;
      pixel_out <= (t1 && !brd1) ? res : 8'h00;
    end
  end
endmodule

// File: tb/tb_sobel_3x3_gray8.sv
// tb_sobel_3x3_gray8: scoreboard bench for sobel_3x3_gray8 (reference Sobel model on a stored frame)
module tb_sobel_3x3_gray8;
  localparam int W = 320;
  logic clk, rst, enable, vsync, active_area, thresh_sel, filter_ready;
  logic [7:0] pixel_in, thresh_in, pixel_out;
  typedef struct {int acc; int val;} sb_t;
  sb_t sb[$];
  int img [8][W];
  int cyc = 0, nready = 0, checks = 0, failures = 0, thr_now = 64;

  sobel_3x3_gray8 dut (
    .clk(clk), .rst(rst), .enable(enable), .pixel_in(pixel_in), .vsync(vsync),
    .active_area(active_area), .thresh_sel(thresh_sel), .thresh_in(thresh_in),
    .pixel_out(pixel_out), .filter_ready(filter_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int iabs(input int x);
    return x < 0 ? -x : x;
  endfunction

  // Output for the pixel accepted at (c,r): window rows r-2..r, cols c-2..c
  function automatic int exp_at(input int r, input int c);
    int gx, gy, m;
    if (r < 2 || c < 2) return 0;
    gx = img[r-2][c] + 2*img[r-1][c] + img[r][c] - img[r-2][c-2] - 2*img[r-1][c-2] - img[r][c-2];
    gy = img[r][c-2] + 2*img[r][c-1] + img[r][c] - img[r-2][c-2] - 2*img[r-2][c-1] - img[r-2][c];
    m = iabs(gx) + iabs(gy);
    m = m > 255 ? 255 : m;
`ifdef SOBEL_THRESH_EN
    m = m >= thr_now ? 255 : 0;
`endif
    return m;
  endfunction

  task automatic fill(input int mode, input int rows);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = mode == 0 ? 100 : mode == 1 ? (c < 160 ? 0 : 255) :
                    mode == 3 ? (20 * c) % 256 : int'($urandom_range(0, 255));
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (filter_ready) begin
      nready++;
      if (sb.size() == 0) check("spurious_ready", filter_ready, 0);
      else begin
        e = sb.pop_front();
        check("latency", cyc, e.acc + 3);
        check("pixel", pixel_out, e.val);
      end
    end else begin
      check("idle_out", pixel_out, 0);
      if (sb.size() > 0 && cyc >= sb[0].acc + 3) begin
        check("missing_ready", filter_ready, 1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic pulse_rst();
    rst = 1'b1;
    enable = 1'b1;
    active_area = 1'b1;
    pixel_in = 8'($urandom);
    while (sb.size() > 0 && sb[$].acc >= cyc - 2) void'(sb.pop_back());
    step(1);
    rst = 1'b0;
    enable = 1'b0;
    active_area = 1'b0;
    check("rst_ready", filter_ready, 0);
    check("rst_out", pixel_out, 0);
    step(8);
  endtask

  task automatic run_frame(input int rows, input bit tog, input bit vs_co, input int rst_r, input int rst_c);
    int n0;
    n0 = nready;
    thresh_sel = 1'b1;
    thresh_in = 8'(thr_now);
    if (!vs_co) begin
      vsync = 1'b1;
      step(2);
      vsync = 1'b0;
      step(2);
    end
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == rst_r && c == rst_c) begin
          pulse_rst();
          return;
        end
        vsync = vs_co && r == 0 && c == 0;
        active_area = 1'b1;
        enable = 1'b1;
        pixel_in = 8'(img[r][c]);
        sb.push_back('{cyc, exp_at(r, c)});
        step(1);
        if (tog) begin
          enable = 1'b0;
          pixel_in = 8'($urandom);
          step(1);
        end
      end
      vsync = 1'b0;
      active_area = 1'b0;
      enable = 1'($urandom);
      step(4);
    end
    enable = 1'b0;
    step(6);
    check("ready_cnt", nready - n0, rows * W);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    vsync = 1'b0;
    active_area = 1'b0;
    pixel_in = 8'h00;
    thresh_sel = 1'b0;
    thresh_in = 8'h00;
    step(3);
    check("reset_ready", filter_ready, 0);
    check("reset_out", pixel_out, 0);
    rst = 1'b0;
    step(2);
    fill(0, 8);
    run_frame(8, 1'b0, 1'b0, -1, -1);
    fill(1, 8);
    run_frame(8, 1'b0, 1'b0, -1, -1);
    fill(2, 6);
    run_frame(6, 1'b0, 1'b0, -1, -1);
    run_frame(6, 1'b1, 1'b0, -1, -1);
    fill(3, 4);
    thr_now = 200;
    run_frame(4, 1'b0, 1'b0, -1, -1);
    thr_now = 80;
    run_frame(4, 1'b0, 1'b0, -1, -1);
    thr_now = 64;
    fill(2, 8);
    run_frame(8, 1'b0, 1'b0, 5, 100);
    fill(2, 6);
    run_frame(6, 1'b0, 1'b0, -1, -1);
    fill(2, 5);
    run_frame(5, 1'b0, 1'b1, -1, -1);
    check("queue_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
